// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the shift arbiter controller.
// Tie-break policy is selected by SHFCTL_FIXED_PRIO_EN inside rr_arbiter_2.
package shift_ctrl_pkg;

    localparam int DW_DEF       = 16;
    localparam int SW_DEF       = 4;
    localparam int STEP_MAX_DEF = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way request arbiter with last-served pointer.
// Define SHFCTL_FIXED_PRIO_EN to make requester 0 always win ties (no pointer).
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

`ifdef SHFCTL_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, update};

    always_comb begin
        grant = 2'b00;
        if (req[0])
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end
`else
    // Index of the requester served most recently; reset value lets 0 win first tie.
    logic last_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_reg <= 1'b1;
        else if (update)
            last_reg <= grant[1];
    end

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last_reg ? 2'b01 : 2'b10;
    end
`endif

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Sequences shift operations from two requesters onto one shared registered shifter.
// Tie-break policy follows SHFCTL_FIXED_PRIO_EN (see rr_arbiter_2).
module shift_arbiter_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int SW       = SW_DEF,
    parameter int STEP_MAX = STEP_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0][DW-1:0] req_data,
    input  logic [1:0][SW-1:0] req_amt,
    input  logic [1:0]         req_dir,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DW-1:0]      rsp_data,
    output logic               shf_load,
    output logic               shf_enb,
    output logic [DW-1:0]      shf_data,
    output logic [SW-1:0]      shf_value,
    output logic               shf_dir,
    input  logic [DW-1:0]      shf_q,
    output logic               busy
);

    localparam logic [SW-1:0] STEP = SW'(STEP_MAX);

    state_t        state_reg, state_next;
    logic [DW-1:0] data_reg;
    logic [SW-1:0] rem_reg;
    logic          dir_reg;
    logic          id_reg;

    logic [1:0]    grant;
    logic          accept;
    logic          sel;
    logic [SW-1:0] step;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .update (accept),
        .grant  (grant)
    );

    assign accept = (state_reg == IDLE) && (grant != 2'b00);
    assign sel    = grant[1];
    assign step   = (rem_reg > STEP) ? STEP : rem_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            rem_reg   <= '0;
            dir_reg   <= 1'b0;
            id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                data_reg <= req_data[sel];
                rem_reg  <= req_amt[sel];
                dir_reg  <= req_dir[sel];
                id_reg   <= sel;
            end else if (state_reg == SHIFT) begin
                rem_reg <= rem_reg - step;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 2'b00;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_data   = '0;
        shf_load   = 1'b0;
        shf_enb    = 1'b0;
        shf_data   = '0;
        shf_value  = '0;
        shf_dir    = DIR_LEFT;
        case (state_reg)
            IDLE: begin
                // Gate with reset so grants vanish the moment reset asserts.
                req_ready = rst ? grant : 2'b00;
                if (accept)
                    state_next = LOAD;
            end
            LOAD: begin
                shf_load   = 1'b1;
                shf_data   = data_reg;
                shf_dir    = dir_reg;
                state_next = (rem_reg == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                shf_enb   = 1'b1;
                shf_value = step;
                shf_dir   = dir_reg;
                if (rem_reg == step)
                    state_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_id    = id_reg;
                rsp_data  = shf_q;
                shf_dir   = dir_reg;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench for shift_arbiter_ctrl with a behavioural shifter and response scoreboard.
// Grant-order expectations follow SHFCTL_FIXED_PRIO_EN when defined.
module tb_shift_arbiter_ctrl;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][15:0] req_data = '0;
    logic [1:0][3:0]  req_amt = '0;
    logic [1:0]       req_dir = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_id;
    logic [15:0]      rsp_data;
    logic             shf_load;
    logic             shf_enb;
    logic [15:0]      shf_data;
    logic [3:0]       shf_value;
    logic             shf_dir;
    logic [15:0]      shf_q = '0;
    logic             busy;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          lat;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    int   enb_log[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rsp_seen = 1'b0;

    always #5 clk = ~clk;

    shift_arbiter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .shf_load  (shf_load),
        .shf_enb   (shf_enb),
        .shf_data  (shf_data),
        .shf_value (shf_value),
        .shf_dir   (shf_dir),
        .shf_q     (shf_q),
        .busy      (busy)
    );

    // Behavioural shared shifter
    always @(posedge clk) begin
        if (shf_load)
            shf_q <= shf_data;
        else if (shf_enb)
            shf_q <= shf_dir ? (shf_q >> shf_value) : (shf_q << shf_value);
    end

    // Scoreboard: push golden result on request handshake, compare on response rise
    always @(negedge clk) begin
        exp_t        e;
        int          id;
        int          a;
        logic [15:0] d;
        cyc++;
        if (!rst) begin
            rsp_seen = 1'b0;
        end else begin
            if (rsp_valid && !rsp_seen) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stale_rsp: got id=%0d data=%h, required no response", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id[0] || rsp_data !== e.data || (cyc - e.start) !== e.lat) begin
                        n_fail++;
                        $display("FAIL rsp: got id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                                 rsp_id, rsp_data, cyc - e.start, e.id, e.data, e.lat);
                    end
                    $display("rsp id=%0d data=%h lat=%0d", rsp_id, rsp_data, cyc - e.start);
                end
            end
            rsp_seen = rsp_valid;
            if (shf_enb)
                enb_log.push_back(int'(shf_value));
            if ((req_valid & req_ready) != 2'b00) begin
                id = req_ready[1] ? 1 : 0;
                d  = req_data[id];
                a  = int'(req_amt[id]);
                e.id    = id;
                e.data  = req_dir[id] ? (d >> a) : (d << a);
                e.lat   = 2 + (a + 3) / 4;
                e.start = cyc;
                exp_q.push_back(e);
                grant_log.push_back(id);
                $display("req id=%0d data=%h amt=%0d dir=%0d", id, d, a, req_dir[id]);
            end
        end
    end

    task automatic send(input int id, input logic [15:0] d, input logic [3:0] a, input logic dir);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_data[id]  = d;
        req_amt[id]   = a;
        req_dir[id]   = dir;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready[id];
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL grant_timeout: req %0d never granted, required grant", id);
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        #2;
        n_checks++;
        if ({req_ready, rsp_valid, shf_load, shf_enb, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b rsp_valid=%b load=%b enb=%b busy=%b, required all 0",
                     req_ready, rsp_valid, shf_load, shf_enb, busy);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b ready=%b, required 0 00", busy, req_ready);
        end
    endtask

    task automatic test_contention;
        int exp_g[4];
`ifdef SHFCTL_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        grant_log.delete();
        @(posedge clk); #1;
        req_data[0] = 16'h00F0; req_amt[0] = 4'd3; req_dir[0] = 1'b0;
        req_data[1] = 16'h8001; req_amt[1] = 4'd5; req_dir[1] = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_checks++;
        if (grant_log.size() !== 4) begin
            n_fail++;
            $display("FAIL contention_count: got %0d grants, required 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grant_log[i] !== exp_g[i]) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d: got %0d, required %0d", i, grant_log[i], exp_g[i]);
                end
            end
        end
        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL contention_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_single;
        enb_log.delete();
        send(0, 16'h0008, 4'd2, 1'b0);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || enb_log.size() != 1 || enb_log[0] != 2) begin
            n_fail++;
            $display("FAIL single_steps: got pending=%0d enb_pulses=%0d, required 0 pending and one step of 2",
                     exp_q.size(), enb_log.size());
        end
    endtask

    task automatic test_multi;
        int exp_s[3] = '{4, 4, 2};
        enb_log.delete();
        send(0, 16'hFFFF, 4'd10, 1'b1);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        n_checks++;
        if (enb_log.size() != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL multi_count: got %0d steps pending=%0d, required 3 steps 0 pending",
                     enb_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (enb_log[i] != exp_s[i]) begin
                    n_fail++;
                    $display("FAIL multi_step%0d: got %0d, required %0d", i, enb_log[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_zero;
        enb_log.delete();
        send(1, 16'h1234, 4'd0, 1'b0);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        n_checks++;
        if (enb_log.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_amt: got %0d enb pulses pending=%0d, required 0 and 0", enb_log.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        bit got = 1'b0;
        rsp_ready = 1'b0;
        send(0, 16'h0F0F, 4'd4, 1'b1);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #1;
            got = rsp_valid;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL bp_rsp_timeout: got no rsp_valid, required rsp_valid");
        end
        req_data[1] = 16'h0001; req_amt[1] = 4'd1; req_dir[1] = 1'b0;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (rsp_data !== 16'h00F0 || req_ready !== 2'b00 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got data=%h ready=%b busy=%b valid=%b, required 00f0 00 1 1",
                         i, rsp_data, req_ready, busy, rsp_valid);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b valid=%b ready=%b, required 0 0 10", busy, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        enb_log.delete();
        send(0, 16'hABCD, 4'd12, 1'b0);
        for (int i = 0; i < 50 && enb_log.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, shf_load, shf_enb, shf_data, shf_value, shf_dir, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b enb=%b value=%0d load=%b rsp_valid=%b, required all 0",
                     busy, shf_enb, shf_value, shf_load, rsp_valid);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL reset_stale: got %0d rsp cycles, required 0", stray);
        end
        send(1, 16'h00FF, 4'd7, 1'b0);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_recover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_multi();
        test_zero();
        test_backpressure();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
